simd_loop_nest_ctrl: RTL and testbench

//  Sequencer for the SIMD stride-group memory walker. Holds per-group loop trip counts, accepts run requests,
//  and walks the loop nest one step per unstalled cycle. Drives the walker's start/iter_done/block_done/

---
 rtl/simd_pkg.sv | 18 +
 rtl/simd_loop_counter_chain.sv | 42 ++++
 rtl/simd_loop_nest_ctrl.sv | 144 ++++++++++++++
 tb/tb_simd_loop_nest_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD stride-group loop-nest sequencer:
// default widths and the nest FSM state encoding.
package simd_pkg;

    localparam int DEF_LOOP_ID_W      = 5;
    localparam int DEF_GROUP_ID_W     = 2;
    localparam int DEF_ITER_W         = 16;
    localparam int DEF_NUM_MAX_LOOPS  = 1 << DEF_LOOP_ID_W;
    localparam int DEF_NUM_MAX_GROUPS = 1 << DEF_GROUP_ID_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } nest_state_e;

endpackage

// File: rtl/simd_loop_counter_chain.sv
// One counter per nest loop (slot 0 outermost). Produces the combinational
// loop-wrap vector for the current position and advances the nest on step.
module simd_loop_counter_chain
    import simd_pkg::*;
#(
    parameter int NUM_LOOPS = DEF_NUM_MAX_LOOPS,
    parameter int ITER_W    = DEF_ITER_W
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          clear,
    input  logic                          step,
    input  logic [NUM_LOOPS*ITER_W-1:0]   trip_row,
    output logic [NUM_LOOPS:0]            iter_vec
);

    logic [NUM_LOOPS-1:0] last;

    assign iter_vec[NUM_LOOPS] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LOOPS; gi++) begin : g_loop
            logic [ITER_W-1:0] cnt_reg;

            assign last[gi]     = (cnt_reg == trip_row[gi*ITER_W +: ITER_W]);
            // Loop gi wraps only when it and every loop inside it sit at their last iteration.
            assign iter_vec[gi] = &last[NUM_LOOPS-1:gi];

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    cnt_reg <= '0;
                end else if (clear) begin
                    cnt_reg <= '0;
                end else if (step && iter_vec[gi+1]) begin
                    cnt_reg <= last[gi] ? '0 : cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/simd_loop_nest_ctrl.sv
// Loop-nest sequencer: per-group trip table with slot pointers, run FSM and
// registered walker controls (start, iter_done, block_done, loop_group_id).
module simd_loop_nest_ctrl
    import simd_pkg::*;
#(
    parameter int LOOP_ID_W      = DEF_LOOP_ID_W,
    parameter int GROUP_ID_W     = DEF_GROUP_ID_W,
    parameter int ITER_W         = DEF_ITER_W,
    parameter int NUM_MAX_LOOPS  = 1 << LOOP_ID_W,
    parameter int NUM_MAX_GROUPS = 1 << GROUP_ID_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cfg_loop_iter_v,
    input  logic [ITER_W-1:0]        cfg_loop_iter,
    input  logic [GROUP_ID_W-1:0]    cfg_loop_group_id,
    input  logic                     cfg_block_done,
    input  logic                     run_req,
    input  logic [GROUP_ID_W-1:0]    run_group_id,
    output logic                     run_ready,
    output logic                     run_done,
    input  logic                     stall,
    output logic                     start,
    output logic [NUM_MAX_LOOPS:0]   iter_done,
    output logic                     block_done,
    output logic [GROUP_ID_W-1:0]    loop_group_id
);

    localparam int L     = NUM_MAX_LOOPS;
    localparam int G     = NUM_MAX_GROUPS;
    localparam int PTR_W = LOOP_ID_W + 1;

    nest_state_e            state_reg;
    logic                   start_reg;
    logic                   run_done_reg;
    logic                   run_ready_reg;
    logic                   block_done_reg;
    logic [L:0]             iter_done_reg;
    logic [GROUP_ID_W-1:0]  grp_reg;

    logic [L*ITER_W-1:0]    trip_rows [G];
    logic [L:0]             chain_vec;
    logic                   busy;
    logic                   accept;
    logic                   issue;

    assign busy   = (state_reg != S_IDLE);
    assign accept = (state_reg == S_IDLE) && run_req;
    // A step is issued from START or from RUN until the final step has gone out.
    assign issue  = !stall && ((state_reg == S_START) ||
                               ((state_reg == S_RUN) && !iter_done_reg[0]));

    genvar gi;
    generate
        for (gi = 0; gi < G; gi++) begin : g_grp
            logic [PTR_W-1:0]    ptr_reg;
            logic [L*ITER_W-1:0] row_reg;
            logic                wr_hit;

            assign wr_hit = cfg_loop_iter_v && (cfg_loop_group_id == GROUP_ID_W'(gi)) &&
                            (ptr_reg != PTR_W'(L)) &&
                            !(busy && (grp_reg == GROUP_ID_W'(gi)));

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    ptr_reg <= '0;
                    row_reg <= '0;
                end else if (cfg_block_done) begin
                    ptr_reg <= '0;
                    row_reg <= '0;
                end else if (wr_hit) begin
                    row_reg[ptr_reg[LOOP_ID_W-1:0]*ITER_W +: ITER_W] <= cfg_loop_iter;
                    ptr_reg <= ptr_reg + 1'b1;
                end
            end

            assign trip_rows[gi] = row_reg;
        end
    endgenerate

    simd_loop_counter_chain #(
        .NUM_LOOPS (L),
        .ITER_W    (ITER_W)
    ) u_chain (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (accept),
        .step     (issue),
        .trip_row (trip_rows[grp_reg]),
        .iter_vec (chain_vec)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= S_IDLE;
            start_reg      <= 1'b0;
            run_done_reg   <= 1'b0;
            run_ready_reg  <= 1'b1;
            block_done_reg <= 1'b0;
            iter_done_reg  <= '0;
            grp_reg        <= '0;
        end else begin
            block_done_reg <= cfg_block_done;
            start_reg      <= 1'b0;
            run_done_reg   <= 1'b0;
            iter_done_reg  <= '0;
            unique case (state_reg)
                S_IDLE: begin
                    if (run_req) begin
                        state_reg     <= S_START;
                        start_reg     <= 1'b1;
                        run_ready_reg <= 1'b0;
                        grp_reg       <= run_group_id;
                    end
                end
                S_START: begin
                    state_reg <= S_RUN;
                    if (issue) iter_done_reg <= chain_vec;
                end
                S_RUN: begin
                    if (iter_done_reg[0]) begin
                        state_reg    <= S_DONE;
                        run_done_reg <= 1'b1;
                    end else if (issue) begin
                        iter_done_reg <= chain_vec;
                    end
                end
                S_DONE: begin
                    state_reg     <= S_IDLE;
                    run_ready_reg <= 1'b1;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign run_ready     = run_ready_reg;
    assign run_done      = run_done_reg;
    assign start         = start_reg;
    assign iter_done     = iter_done_reg;
    assign block_done    = block_done_reg;
    assign loop_group_id = grp_reg;

endmodule

// File: tb/tb_simd_loop_nest_ctrl.sv
// Self-checking bench for simd_loop_nest_ctrl: directed table of nests, hand-written
// corner sequences and randomized runs checked against an odometer model.
module tb_simd_loop_nest_ctrl;
    import simd_pkg::*;

    localparam int L  = DEF_NUM_MAX_LOOPS;
    localparam int G  = DEF_NUM_MAX_GROUPS;
    localparam int IW = DEF_ITER_W;
    localparam int GW = DEF_GROUP_ID_W;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cfg_loop_iter_v;
    logic [IW-1:0] cfg_loop_iter;
    logic [GW-1:0] cfg_loop_group_id;
    logic          cfg_block_done;
    logic          run_req;
    logic [GW-1:0] run_group_id;
    logic          run_ready;
    logic          run_done;
    logic          stall;
    logic          start;
    logic [L:0]    iter_done;
    logic          block_done;
    logic [GW-1:0] loop_group_id;

    always #5 clk = ~clk;

    simd_loop_nest_ctrl dut (
        .clk               (clk),
        .resetn            (resetn),
        .cfg_loop_iter_v   (cfg_loop_iter_v),
        .cfg_loop_iter     (cfg_loop_iter),
        .cfg_loop_group_id (cfg_loop_group_id),
        .cfg_block_done    (cfg_block_done),
        .run_req           (run_req),
        .run_group_id      (run_group_id),
        .run_ready         (run_ready),
        .run_done          (run_done),
        .stall             (stall),
        .start             (start),
        .iter_done         (iter_done),
        .block_done        (block_done),
        .loop_group_id     (loop_group_id)
    );

    int checks = 0;
    int errors = 0;
    int model_trip [G][L];
    int model_ptr  [G];

    typedef struct {
        int grp;
        int nslots;
        int trips [4];
        int mode;       // 0 no stall, 1 random stall, 2 stall for 3 cycles after step 1
        int exp_steps;
    } vec_t;
    vec_t tbl [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int g = 0; g < G; g++) begin
            model_ptr[g] = 0;
            for (int k = 0; k < L; k++) model_trip[g][k] = 0;
        end
    endfunction

    function automatic void model_write(input int g, input int val);
        if (model_ptr[g] < L) begin
            model_trip[g][model_ptr[g]] = val;
            model_ptr[g]++;
        end
    endfunction

    function automatic int model_steps(input int g);
        int p = 1;
        for (int k = 0; k < L; k++) p = p * (model_trip[g][k] + 1);
        return p;
    endfunction

    // Step s (0-based) wraps loop k when s+1 is a multiple of the iteration count of loops k..L-1.
    function automatic logic [L:0] exp_vec(input int g, input int s);
        logic [L:0] v;
        longint     p = 1;
        v[L] = 1'b1;
        for (int k = L - 1; k >= 0; k--) begin
            p    = p * longint'(model_trip[g][k] + 1);
            v[k] = ((longint'(s) + 1) % p) == 0;
        end
        return v;
    endfunction

    task automatic cfg_write(input int g, input int val);
        cfg_loop_iter_v   = 1'b1;
        cfg_loop_group_id = GW'(g);
        cfg_loop_iter     = IW'(val);
        tick();
        cfg_loop_iter_v   = 1'b0;
        model_write(g, val);
    endtask

    task automatic do_block_done(input bit with_write);
        cfg_block_done = 1'b1;
        if (with_write) begin
            cfg_loop_iter_v   = 1'b1;
            cfg_loop_group_id = GW'(1);
            cfg_loop_iter     = IW'(3);
        end
        tick();
        cfg_block_done  = 1'b0;
        cfg_loop_iter_v = 1'b0;
        model_clear();
        check("block_done_pulse", 64'(block_done), 64'd1);
        tick();
        check("block_done_clear", 64'(block_done), 64'd0);
    endtask

    task automatic run_nest(input int g, input int mode, input bit inject, output int steps);
        int  n;
        int  k;
        int  cyc;
        bit  fin;
        bit  stall_now;
        n     = model_steps(g);
        k     = 0;
        cyc   = 0;
        fin   = 1'b0;
        steps = 0;
        check("run_ready_idle", 64'(run_ready), 64'd1);
        run_req      = 1'b1;
        run_group_id = GW'(g);
        tick();
        run_req = 1'b0;
        check("start_pulse", 64'(start), 64'd1);
        check("run_ready_busy", 64'(run_ready), 64'd0);
        check("start_iter_done", 64'(iter_done), 64'd0);
        check("start_group", 64'(loop_group_id), 64'(g));
        while (!fin && cyc < 500) begin
            stall_now = (mode == 1) ? ($urandom_range(0, 2) == 0)
                                    : ((mode == 2) && cyc >= 1 && cyc <= 3);
            stall           = stall_now;
            cfg_loop_iter_v = inject && (cyc == 1 || cyc == 2);
            cfg_loop_group_id = (cyc == 1) ? GW'(g) : GW'(0);
            cfg_loop_iter     = (cyc == 1) ? IW'(7) : IW'(4);
            tick();
            if (inject && cyc == 2) model_write(0, 4);
            cyc++;
            check("run_start_low", 64'(start), 64'd0);
            check("run_group", 64'(loop_group_id), 64'(g));
            if (k < n) begin
                check("step_iter_done", 64'(iter_done), stall_now ? 64'd0 : 64'(exp_vec(g, k)));
                check("step_run_done", 64'(run_done), 64'd0);
                if (!stall_now) k++;
                if (iter_done != '0) steps++;
            end else begin
                check("run_done_pulse", 64'(run_done), 64'd1);
                check("done_iter_done", 64'(iter_done), 64'd0);
                fin = 1'b1;
            end
        end
        cfg_loop_iter_v = 1'b0;
        stall           = 1'b0;
        if (!fin) begin
            errors++;
            $display("FAIL run_timeout: actual=no run_done required=run_done within 500 cycles");
        end
        tick();
        check("post_run_done", 64'(run_done), 64'd0);
        check("post_run_ready", 64'(run_ready), 64'd1);
        $display("run grp=%0d mode=%0d inject=%0d steps=%0d cycles=%0d", g, mode, inject, steps, cyc);
    endtask

    initial begin
        int s;
        int g;
        int ns;
        tbl[0] = '{0, 2, '{1, 2, 0, 0}, 0, 6};
        tbl[1] = '{0, 2, '{1, 2, 0, 0}, 2, 6};
        tbl[2] = '{3, 0, '{0, 0, 0, 0}, 0, 1};
        tbl[3] = '{2, 1, '{3, 0, 0, 0}, 1, 4};
        tbl[4] = '{1, 3, '{0, 1, 2, 0}, 1, 6};

        resetn = 1'b0; cfg_loop_iter_v = 1'b0; cfg_loop_iter = '0; cfg_loop_group_id = '0;
        cfg_block_done = 1'b0; run_req = 1'b0; run_group_id = '0; stall = 1'b0;
        model_clear();
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        check("reset_run_ready", 64'(run_ready), 64'd1);
        check("reset_start", 64'(start), 64'd0);
        check("reset_iter_done", 64'(iter_done), 64'd0);
        check("reset_run_done", 64'(run_done), 64'd0);
        check("reset_block_done", 64'(block_done), 64'd0);
        check("reset_group", 64'(loop_group_id), 64'd0);

        // Directed nests from the table.
        for (int i = 0; i < 5; i++) begin
            do_block_done(1'b0);
            for (int j = 0; j < tbl[i].nslots; j++) cfg_write(tbl[i].grp, tbl[i].trips[j]);
            run_nest(tbl[i].grp, tbl[i].mode, 1'b0, s);
            check("table_steps", 64'(s), 64'(tbl[i].exp_steps));
        end

        // L+2 writes to group 1: the last two are dropped.
        do_block_done(1'b0);
        for (int i = 0; i < L + 2; i++) cfg_write(1, (i == 0) ? 1 : ((i >= L) ? 5 : 0));
        run_nest(1, 0, 1'b0, s);
        check("saturate_steps", 64'(s), 64'd2);
        do_block_done(1'b1);
        run_nest(1, 0, 1'b0, s);
        check("cleared_steps", 64'(s), 64'd1);

        // Writes during a run: running group dropped, other group applied.
        do_block_done(1'b0);
        cfg_write(2, 3);
        cfg_write(0, 1);
        run_nest(2, 0, 1'b1, s);
        check("busy_run_steps", 64'(s), 64'd4);
        run_nest(2, 0, 1'b0, s);
        check("busy_drop_steps", 64'(s), 64'd4);
        run_nest(0, 0, 1'b0, s);
        check("busy_apply_steps", 64'(s), 64'd10);

        // Reset asserted at step 3 of a 6-step nest.
        do_block_done(1'b0);
        cfg_write(0, 1);
        cfg_write(0, 2);
        run_req = 1'b1; run_group_id = '0;
        tick();
        run_req = 1'b0;
        repeat (3) tick();
        check("pre_reset_step3", 64'(iter_done), 64'(exp_vec(0, 2)));
        resetn = 1'b0;
        #1;
        check("midrun_reset_iter_done", 64'(iter_done), 64'd0);
        check("midrun_reset_start", 64'(start), 64'd0);
        check("midrun_reset_run_done", 64'(run_done), 64'd0);
        model_clear();
        tick();
        resetn = 1'b1;
        tick();
        check("post_reset_run_done", 64'(run_done), 64'd0);
        run_nest(0, 0, 1'b0, s);
        check("post_reset_steps", 64'(s), 64'd1);

        // Randomized nests with random stall.
        for (int r = 0; r < 8; r++) begin
            do_block_done(1'b0);
            g  = $urandom_range(0, G - 1);
            ns = $urandom_range(0, 3);
            for (int j = 0; j < ns; j++) cfg_write(g, $urandom_range(0, 2));
            cfg_write((g + 1) % G, $urandom_range(0, 3));
            run_nest(g, 1, 1'b0, s);
            check("random_steps", 64'(s), 64'(model_steps(g)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
